// File: rtl/mem_arbiter.sv
// Two-port instruction/data arbiter onto a single memory port.
// One transaction in flight; data has priority but fetch cannot starve.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [1:0]        dm_size_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [1:0]        mem_size_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              win_dm_q, win_dm_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic any_req;
  logic fetch_win;
  logic accept;

  assign any_req   = if_req_i | dm_req_i;
  assign fetch_win = if_req_i &
                     (~dm_req_i | (starve_q == SW'(STARVE_LIMIT)));
  assign accept    = rst_ni & (state_q == IDLE) & any_req;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    win_dm_d    = win_dm_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = REQ;
          mem_req_d = 1'b1;
          win_dm_d  = ~fetch_win;
          if (fetch_win) begin
            starve_d    = '0;
            mem_we_d    = 1'b0;
            mem_size_d  = 2'b10;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
          end else begin
            if (if_req_i) starve_d = starve_q + 1'b1;
            mem_we_d    = dm_we_i;
            mem_size_d  = dm_size_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          state_d   = RSP;
          mem_req_d = 1'b0;
        end
      end
      RSP: begin
        if (mem_rvalid_i) begin
          state_d = DONE;
          // a store's response is only an acknowledge
          if (win_dm_q) begin
            dm_rvalid_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = mem_rdata_i;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      win_dm_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      win_dm_q    <= win_dm_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_gnt_o    = accept & fetch_win;
  assign dm_gnt_o    = accept & ~fetch_win;
  assign if_rvalid_o = if_rvalid_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_stall_o  = rst_ni & if_req_i & ~if_rvalid_q;
  assign dm_stall_o  = rst_ni & dm_req_i & ~dm_rvalid_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_size_o  = mem_size_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width of every address port.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width of every read and write data port.
REQ-003 Parameter STARVE_LIMIT, default 3, SHALL set the number of consecutive data wins after which fetch is forced to win.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- clk_i  in  1  clock; rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- if_req_i  in  1  fetch request; held until if_rvalid_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_gnt_o  out  1  fetch accepted; 1-cycle pulse.
- if_rvalid_o  out  1  fetch data valid; 1-cycle pulse.
- if_rdata_o  out  DATA_W  fetch read data.
- if_stall_o  out  1  fetch stalled = if_req_i & ~if_rvalid_o.
- dm_req_i  in  1  data request; held until dm_rvalid_o.
- dm_we_i  in  1  store when 1, load when 0.
- dm_size_i  in  2  access size: 00 byte, 01 half, 10 word.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  store data.
- dm_gnt_o  out  1  data accepted; 1-cycle pulse.
- dm_rvalid_o  out  1  load data or store acknowledge; 1-cycle pulse.
- dm_rdata_o  out  DATA_W  load data.
- dm_stall_o  out  1  data stalled = dm_req_i & ~dm_rvalid_o.
- mem_req_o, mem_we_o  out  1  memory request and write enable.
- mem_size_o  out  2  memory access size; 10 for fetch.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_gnt_i, mem_rvalid_i  in  1  memory accept and memory response.
- mem_rdata_i  in  DATA_W  memory read data.

Function
REQ-005 The block SHALL have states IDLE, REQ, RSP and DONE, with at most one memory transaction outstanding.
REQ-006 In IDLE with any request, the block SHALL select a winner, latch the winner's fields into the mem_* registers, pulse the winner's gnt_o that cycle, and go to REQ.
REQ-007 Arbitration SHALL be: data wins over fetch, except that fetch wins when starve_cnt == STARVE_LIMIT.
REQ-008 starve_cnt SHALL increment on each arbitration where both requests are present and data wins, and SHALL clear whenever fetch wins.
REQ-009 In REQ, mem_req_o SHALL be 1; on mem_gnt_i the block SHALL go to RSP and drop mem_req_o in that next cycle.
REQ-010 In RSP, on mem_rvalid_i the block SHALL register mem_rdata_i into the winner's rdata output and go to DONE.
REQ-011 In DONE, the winner's rvalid_o SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-012 IDLE SHALL NOT re-accept a request in the cycle of its rvalid_o, because DONE separates the two.
REQ-013 A store SHALL also wait for mem_rvalid_i as its write acknowledge; dm_rdata_o SHALL be held unchanged for a store.
REQ-014 Fetch SHALL drive mem_we_o=0, mem_size_o=10 and mem_wdata_o=0.
REQ-015 Minimum latency SHALL be: request in cycle 0, mem_req_o in cycle 1, gnt_i in cycle 1, rvalid_i in cycle 2, rvalid_o in cycle 3.
REQ-016 mem_gnt_i outside REQ and mem_rvalid_i outside RSP SHALL be ignored.
REQ-017 A requester dropping its request mid-transaction SHALL NOT abort the transaction; its rvalid_o still pulses.
REQ-018 mem_* outputs SHALL stay stable from REQ entry until the grant.
REQ-019 rdata outputs SHALL hold their last value until the next response to the same port.
REQ-020 There SHALL be no timeout: REQ and RSP wait indefinitely.

Reset
REQ-021 With rst_ni low, asynchronously: state SHALL be IDLE, starve_cnt 0, and all outputs 0, including rdata.
REQ-022 Reset mid-transaction SHALL abandon the transaction; a mem_rvalid_i after release SHALL be ignored (REQ-016).
REQ-023 The first arbitration SHALL occur on the first rising edge with rst_ni high.

Verification
REQ-024 Single fetch: if_addr_i=0x100, gnt_i in cycle 1, rvalid_i in cycle 2 with rdata 0x00500093 -> if_rvalid_o in cycle 3 with 0x00500093; if_stall_o 1 in cycles 0-2.
REQ-025 Simultaneous requests: dm load 0x2000 and fetch 0x104 -> data granted first; fetch granted in the IDLE following data's DONE.
REQ-026 Starvation: fetch held and 4 back-to-back data requests, STARVE_LIMIT=3 -> order D,D,D,F,D; starve_cnt cleared after F.
REQ-027 Store: dm_we_i=1, size 01, addr 0x2002, wdata 0xBEEF -> mem_we_o=1, mem_size_o=01; dm_rvalid_o pulses after rvalid_i; dm_rdata_o unchanged.
REQ-028 Grant stall: mem_gnt_i low for 5 cycles -> mem_req_o and fields stable for 5 cycles; a spurious mem_rvalid_i in REQ is ignored.
REQ-029 Reset in RSP: rst_ni low for 1 cycle -> IDLE and outputs 0 immediately; a later mem_rvalid_i produces no rvalid_o.
